// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the I-cache fill side and the load/store side.
// One transaction at a time, round-robin on ties, registered memory controls; min 3 cycles per access.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_owner;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_i, grant_d;
  logic              stall_hit;
  logic              mem_ack;

  // Tie goes to the side that did not win last time (last_owner=1 means D won).
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_owner)) begin
          grant_i   = 1'b1;
          state_nxt = GRANT_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_rdy) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_ack   = (state == GRANT_I || state == GRANT_D) && mem_rdy;
  assign busy      = (state != IDLE);
  assign stall_hit = (i_req && !(busy && !owner)) || (d_req && !(busy && owner));
  assign i_done    = (state == DONE) && !owner;
  assign d_done    = (state == DONE) && owner;
  assign i_rdata   = i_done ? rdata_q : '0;
  assign d_rdata   = d_done ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdata_q     <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        owner      <= 1'b0;
        last_owner <= 1'b0;
        mem_re     <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= i_addr;
        mem_wdata  <= '0;
      end else if (grant_d) begin
        owner      <= 1'b1;
        last_owner <= 1'b1;
        mem_re     <= !d_we;
        mem_we     <= d_we;
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
      end else if (mem_ack) begin
        // mem_we still reflects the finishing access; writes report zero data.
        mem_re  <= 1'b0;
        mem_we  <= 1'b0;
        rdata_q <= mem_we ? '0 : mem_rdata;
      end
      if (grant_i && i_grant_cnt != '1) i_grant_cnt <= i_grant_cnt + CNT_W'(1);
      if (grant_d && d_grant_cnt != '1) d_grant_cnt <= d_grant_cnt + CNT_W'(1);
      if (stall_hit && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model feeds a scoreboard
// that is drained by independent memory-side and done-side monitors.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_done, d_done, mem_re, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdy = 1'b0;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt, stall_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy), .owner(owner),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          side;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  int   checks = 0, errors = 0;
  bit   abort = 0;
  txn_t exp_mem_q[$];
  txn_t exp_done_q[$];
  int   lat_q[$];
  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  int   m_icnt, m_dcnt, m_stall;
  logic m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Memory model: counts enabled cycles, answers after the queued latency.
  int            r_cnt = 0, r_lat = 1;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;
  txn_t          r_t;
  always @(negedge clk) begin
    mem_rdy   = 1'b0;
    mem_rdata = DW'($urandom);
    if (rst || !(mem_re || mem_we)) begin
      r_cnt = 0;
    end else begin
      if (r_cnt == 0) begin
        r_lat   = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
      end else begin
        check("mem_addr_hold", mem_addr, s_addr);
        check("mem_we_wdata_hold", {mem_we, mem_wdata}, {s_we, s_wdata});
      end
      r_cnt++;
      if (r_cnt == r_lat) begin
        mem_rdy = 1'b1;
        check("mem_en_excl", mem_re & mem_we, 0);
        if (exp_mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected_access: addr %0h we %0b, none expected", mem_addr, mem_we);
        end else begin
          r_t = exp_mem_q.pop_front();
          check("mem_addr", mem_addr, r_t.addr);
          check("mem_we", mem_we, r_t.we);
          check("owner", owner, r_t.side);
          if (r_t.we) check("mem_wdata", mem_wdata, r_t.wdata);
        end
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
      end
    end
  end

  // Done-side monitor.
  txn_t m_t;
  always @(negedge clk) begin
    if (!rst && (i_done || d_done)) begin
      check("done_excl", i_done & d_done, 0);
      if (exp_done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: i_done %0b d_done %0b, none expected", i_done, d_done);
      end else begin
        m_t = exp_done_q.pop_front();
        check("done_side", d_done, m_t.side);
        check("done_rdata", m_t.side ? d_rdata : i_rdata, m_t.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_icnt = 0; m_dcnt = 0; m_stall = 0; m_last = 1'b1;
    exp_mem_q.delete(); exp_done_q.delete(); lat_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    check("rst_outs", {i_done, d_done, mem_re, mem_we, busy, owner}, 0);
    check("rst_data", {i_rdata, d_rdata}, 0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    check("rst_cnts", {i_grant_cnt, d_grant_cnt, stall_cnt}, 0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic check_cnts();
    check("i_grant_cnt", i_grant_cnt, sat(m_icnt));
    check("d_grant_cnt", d_grant_cnt, sat(m_dcnt));
    check("stall_cnt", stall_cnt, sat(m_stall));
    check("idle_busy", busy, 0);
  endtask

  // mode 0: only side xs; mode 1: both together; mode 2: xs first, other raised in cycle k (1..l1).
  task automatic do_round(input int mode, input logic xs, input int l1, input int l2, input int k,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic dwe, input logic [DW-1:0] dwd);
    logic s [2];
    int   n, cyc, ndone;
    int   exp_cyc [2];
    bit   need_i, need_d, got_i, got_d, drop_i, drop_d;
    txn_t t;
    if (mode == 0)      begin n = 1; s[0] = xs; end
    else if (mode == 1) begin n = 2; s[0] = !m_last; s[1] = m_last; end
    else                begin n = 2; s[0] = xs; s[1] = !xs; end
    for (int j = 0; j < n; j++) begin
      t.side  = s[j];
      t.we    = s[j] ? dwe : 1'b0;
      t.addr  = s[j] ? da : ia;
      t.wdata = t.we ? dwd : '0;
      if (t.we) begin ref_mem[t.addr] = t.wdata; t.rdata = '0; end
      else t.rdata = ref_mem[t.addr];
      exp_mem_q.push_back(t);
      exp_done_q.push_back(t);
      lat_q.push_back(j == 0 ? l1 : l2);
      if (s[j]) m_dcnt++; else m_icnt++;
      m_last = s[j];
    end
    m_stall += (mode == 0) ? 1 : (mode == 1) ? 3 + l1 : 4 + l1 - k;
    exp_cyc[0] = l1 + 1;
    exp_cyc[1] = l1 + l2 + 3;

    i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd;
    if (mode == 1) begin i_req = 1'b1; d_req = 1'b1; end
    else if (xs)   d_req = 1'b1;
    else           i_req = 1'b1;
    need_i = (mode != 0) || !xs;
    need_d = (mode != 0) || xs;
    got_i = 0; got_d = 0; drop_i = 0; drop_d = 0; cyc = 0; ndone = 0;
    while ((need_i && !got_i) || (need_d && !got_d) || i_req || d_req) begin
      tick();
      cyc++;
      if (drop_i) begin i_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_req = 1'b0; drop_d = 0; end
      if (mode == 2 && cyc == k) begin
        if (xs) i_req = 1'b1; else d_req = 1'b1;
      end
      if (i_done || d_done) begin
        if (ndone < 2) check("done_cycle", cyc, exp_cyc[ndone]);
        ndone++;
      end
      if (i_done) begin got_i = 1; drop_i = 1; end
      if (d_done) begin got_d = 1; drop_d = 1; end
      if (cyc > 100) begin
        checks++; errors++;
        $display("FAIL round_timeout: i_done seen %0b d_done seen %0b after %0d cycles", got_i, got_d, cyc);
        i_req = 1'b0; d_req = 1'b0; abort = 1;
        break;
      end
    end
    repeat ($urandom_range(1, 3)) tick();
    check_cnts();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = DW'(a * 16'h9E37 + 1);
      ref_mem[a] = DW'(a * 16'h9E37 + 1);
    end
    mem[16'h0040]     = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;

    do_reset();
    // Lone I read with a slow memory.
    do_round(0, 1'b0, 4, 1, 1, 16'h0040, 16'h0000, 1'b0, 16'h0000);
    // Tie straight after reset: I first, one-cycle memory.
    do_reset();
    if (!abort) do_round(1, 1'b0, 1, 1, 1, 16'h0040, 16'h0041, 1'b0, 16'h0000);
    // D write raised while I is granted.
    if (!abort) do_round(2, 1'b0, 3, 2, 2, 16'h0042, 16'h0100, 1'b1, 16'h1234);
    // Back-to-back ties alternate.
    for (int r = 0; r < 2 && !abort; r++)
      do_round(1, 1'b0, 1 + r, 2, 1, 16'h0100, 16'h0043, 1'b0, 16'h0000);

    for (int r = 0; r < 60 && !abort; r++) begin
      int l1;
      l1 = $urandom_range(1, 4);
      do_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), l1, $urandom_range(1, 4),
               $urandom_range(1, l1), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), DW'($urandom));
    end

    // Reset while D waits on a memory that has not answered.
    if (!abort) begin
      d_addr = 16'h0200; d_we = 1'b0; d_req = 1'b1;
      lat_q.push_back(1000);
      tick(); tick(); tick();
      check("stuck_grant_d", {busy, owner, mem_re}, 3'b111);
      rst = 1'b1; d_req = 1'b0;
      tick();
      check("midrst_en", {mem_re, mem_we}, 0);
      check("midrst_busy_done", {busy, d_done, i_done}, 0);
      check("midrst_cnts", {i_grant_cnt, d_grant_cnt, stall_cnt}, 0);
      rst = 1'b0;
      model_reset();
      repeat (4) tick();
      check("postrst_idle", {busy, d_done, mem_re, mem_we}, 0);
      for (int r = 0; r < 6 && !abort; r++)
        do_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), 2, $urandom_range(1, 3), 1,
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), DW'($urandom));
    end

    check("exp_mem_q_empty", exp_mem_q.size(), 0);
    check("exp_done_q_empty", exp_done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
